// File: rtl/time_set_ctrl.sv
// Time-set controller: debounced sel/up/down buttons drive an hrs/min/sec edit FSM
// that commits the edited time with a one-cycle load strobe.
module time_set_ctrl #(
    parameter int DB_TICKS      = 20,
    parameter int TIMEOUT_TICKS = 10000,
    parameter int INIT_HRS      = 12
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_i,
    input  logic       b_sel,
    input  logic       b_up,
    input  logic       b_down,
    output logic [5:0] set_hrs,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       set_time,
    output logic [1:0] edit_field
);

    localparam int DBW = $clog2(DB_TICKS + 1);
    localparam int TOW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EDIT_HRS = 3'd1,
        EDIT_MIN = 3'd2,
        EDIT_SEC = 3'd3,
        COMMIT   = 3'd4
    } state_t;

    state_t         state;
    logic [2:0]     raw;
    logic [2:0]     sync1;
    logic [2:0]     sync2;
    logic [2:0]     db_lvl;
    logic [2:0]     db_prev;
    logic [2:0]     press;
    logic [DBW-1:0] db_cnt [3];
    logic [TOW-1:0] idle_cnt;
    logic [5:0]     whrs;
    logic [5:0]     wmin;
    logic [5:0]     wsec;
    logic           sel_p;
    logic           up_p;
    logic           down_p;

    assign raw = {b_down, b_up, b_sel};

    // Bit 0 is sel, bit 1 up, bit 2 down throughout the button datapath.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sync1   <= '0;
            sync2   <= '0;
            db_lvl  <= '0;
            db_prev <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            db_prev <= db_lvl;
            if (tick_i) begin
                for (int i = 0; i < 3; i++) begin
                    if (sync2[i] != db_lvl[i]) begin
                        if (db_cnt[i] == DB_LAST) begin
                            db_lvl[i] <= ~db_lvl[i];
                            db_cnt[i] <= '0;
                        end else begin
                            db_cnt[i] <= db_cnt[i] + DBW'(1);
                        end
                    end else begin
                        db_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    assign press  = db_lvl & ~db_prev;
    assign sel_p  = press[0];
    assign up_p   = press[1];
    assign down_p = press[2];

    function automatic logic [5:0] step_field(input logic [5:0] v,
                                              input logic [5:0] max_v,
                                              input logic       inc);
        logic [5:0] r;
        if (inc) begin
            r = (v == max_v) ? 6'd0 : v + 6'd1;
        end else begin
            r = (v == 6'd0) ? max_v : v - 6'd1;
        end
        return r;
    endfunction

    // sel takes priority over up/down; an up+down collision is not an accepted press.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state      <= IDLE;
            set_hrs    <= 6'(INIT_HRS);
            set_min    <= 6'd0;
            set_sec    <= 6'd0;
            whrs       <= 6'd0;
            wmin       <= 6'd0;
            wsec       <= 6'd0;
            idle_cnt   <= '0;
            set_time   <= 1'b0;
            edit_field <= 2'd0;
        end else begin
            set_time <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_p) begin
                        whrs       <= set_hrs;
                        wmin       <= set_min;
                        wsec       <= set_sec;
                        idle_cnt   <= '0;
                        state      <= EDIT_HRS;
                        edit_field <= 2'd1;
                    end
                end
                EDIT_HRS, EDIT_MIN, EDIT_SEC: begin
                    if (sel_p) begin
                        idle_cnt <= '0;
                        case (state)
                            EDIT_HRS: begin
                                state      <= EDIT_MIN;
                                edit_field <= 2'd2;
                            end
                            EDIT_MIN: begin
                                state      <= EDIT_SEC;
                                edit_field <= 2'd3;
                            end
                            default: begin
                                state      <= COMMIT;
                                edit_field <= 2'd0;
                            end
                        endcase
                    end else if (up_p ^ down_p) begin
                        idle_cnt <= '0;
                        case (state)
                            EDIT_HRS: whrs <= step_field(whrs, 6'd23, up_p);
                            EDIT_MIN: wmin <= step_field(wmin, 6'd59, up_p);
                            default:  wsec <= step_field(wsec, 6'd59, up_p);
                        endcase
                    end else if (tick_i) begin
                        if (idle_cnt == TO_LAST) begin
                            idle_cnt   <= '0;
                            state      <= IDLE;
                            edit_field <= 2'd0;
                        end else begin
                            idle_cnt <= idle_cnt + TOW'(1);
                        end
                    end
                end
                COMMIT: begin
                    set_hrs    <= whrs;
                    set_min    <= wmin;
                    set_sec    <= wsec;
                    set_time   <= 1'b1;
                    state      <= IDLE;
                    edit_field <= 2'd0;
                end
                default: begin
                    state      <= IDLE;
                    edit_field <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The parameter list SHALL be exactly as follows.
  - DB_TICKS: default 20; stable ticks required to accept a button level.
  - TIMEOUT_TICKS: default 10000; idle ticks before an edit is abandoned.
  - INIT_HRS: default 12; reset value of the hours field.
REQ-002 The port list SHALL be exactly as follows, clock and reset first.
  - clk_i: input, 1 bit; system clock, the only clock.
  - reset_i: input, 1 bit; synchronous, active-low reset.
  - tick_i: input, 1 bit; 1 kHz enable from the divider, one clk_i cycle wide.
  - b_sel: input, 1 bit; raw select button, asynchronous, bouncy.
  - b_up: input, 1 bit; raw increment button.
  - b_down: input, 1 bit; raw decrement button.
  - set_hrs: output, 6 bits; committed hours, range 0-23.
  - set_min: output, 6 bits; committed minutes, range 0-59.
  - set_sec: output, 6 bits; committed seconds, range 0-59.
  - set_time: output, 1 bit; one-cycle load strobe to the clock cores.
  - edit_field: output, 2 bits; field being edited: 0 none, 1 hrs, 2 min, 3 sec.
REQ-003 All state SHALL be in the clk_i domain, and there SHALL be no latches and no combinational input-to-output paths.

Function
REQ-004 Each button SHALL pass through a 2-flop synchronizer clocked on every clk_i.
REQ-005 Debounce SHALL work as follows for each button.
  - On each tick_i, if the synchronized level differs from the debounced level, a per-button counter increments; otherwise the counter clears.
  - When the counter reaches DB_TICKS, the debounced level toggles and the counter clears.
REQ-006 A 0->1 transition of a debounced level SHALL produce a press pulse one clk_i cycle wide; a 1->0 transition SHALL produce nothing.
REQ-007 The FSM SHALL have the states IDLE, EDIT_HRS, EDIT_MIN, EDIT_SEC and COMMIT, encoded in 3 bits.
REQ-008 In IDLE, a sel press SHALL copy set_hrs, set_min and set_sec into the working registers whrs, wmin and wsec, then go to EDIT_HRS.
REQ-009 A sel press SHALL step EDIT_HRS->EDIT_MIN, EDIT_MIN->EDIT_SEC and EDIT_SEC->COMMIT.
REQ-010 In an EDIT state, an up press SHALL increment the active working field with wrap: hrs 23->0, min/sec 59->0.
REQ-011 In an EDIT state, a down press SHALL decrement the active working field with wrap: hrs 0->23, min/sec 0->59.
REQ-012 Simultaneous up and down presses in the same cycle SHALL be ignored.
REQ-013 When sel arrives in the same cycle as up or down, sel SHALL win and the field SHALL be left unchanged.
REQ-014 Presses outside the EDIT states (up/down in IDLE, anything in COMMIT) SHALL be ignored.
REQ-015 COMMIT SHALL last exactly one clk_i cycle and SHALL perform the following, then go to IDLE.
  - set_hrs, set_min and set_sec take whrs, wmin and wsec at that cycle's clock edge.
  - set_time is 1 in the cycle after that edge, registered, so the consumers see the new values and the strobe together.
REQ-016 set_time SHALL be 0 in every other cycle.
REQ-017 Timeout SHALL work as follows.
  - In an EDIT state, an idle counter increments on tick_i and clears on any accepted press.
  - When it reaches TIMEOUT_TICKS, the FSM returns to IDLE without a commit.
  - On timeout, the set_* outputs are unchanged and set_time stays 0.
REQ-018 edit_field SHALL be a registered decode of the state: IDLE and COMMIT give 0, EDIT_HRS gives 1, EDIT_MIN gives 2, EDIT_SEC gives 3.
REQ-019 The working registers and set_* outputs SHALL never hold out-of-range values, and the arithmetic SHALL be done in 6 bits with explicit wrap compares (no modulo operator).

Reset
REQ-020 When reset_i=0 at a clk_i edge, the following SHALL apply:
  - state=IDLE;
  - set_hrs=INIT_HRS, set_min=0, set_sec=0;
  - set_time=0, edit_field=0;
  - all debounce counters, debounced levels and synchronizer flops=0;
  - idle counter=0, working registers=0.
REQ-021 A reset during EDIT or COMMIT SHALL abandon the edit and produce no set_time pulse.
REQ-022 The first press SHALL be recognized no earlier than DB_TICKS ticks after reset_i returns to 1.

Verification (DB_TICKS=4, TIMEOUT_TICKS=50, tick_i every 10 clk_i)
REQ-023 The bench SHALL cover a reset-value check: hold reset_i=0 for 3 clk_i -> outputs 12/0/0, set_time=0, edit_field=0.
REQ-024 The bench SHALL cover a full edit.
  - Stimulus: sel; then up x2; sel; down x1; sel; up x5; sel, each press held 6 ticks.
  - Required response: set_hrs=14, set_min=59, set_sec=5.
  - Required response: set_time high for exactly 1 clk_i, coincident with the new values.
  - Required response: edit_field sequence 1, 2, 3, 0.
REQ-025 The bench SHALL cover wrap in the hours field.
  - Stimulus: from 23:00:00, press up in EDIT_HRS, then commit. Required response: set_hrs=0.
  - Stimulus: press down at hrs=0. Required response: the field becomes 23.
REQ-026 The bench SHALL cover bounce rejection.
  - Stimulus: b_up toggles every 2 ticks for 20 ticks, then stays high. Required response: exactly one increment.
  - Stimulus: a glitch of 3 ticks. Required response: no increment.
REQ-027 The bench SHALL cover timeout: enter EDIT_MIN, press up, then wait 50 ticks -> state IDLE, set_min unchanged, no set_time pulse.
REQ-028 The bench SHALL cover reset mid-edit: drop reset_i for 1 clk_i while in EDIT_SEC with wsec=30 -> IDLE, 12/0/0, set_time stays 0.
